// File: rtl/microstore_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : microstore_sequencer_if
//  Purpose  : Bundles the microstore sequencing fields, the condition sources
//             and the sequencer's state/status outputs into one bus.
//  Revision : 1.0 - initial release
// ============================================================================
interface microstore_sequencer_if #(
    parameter int STATE_W = 7
);
    logic [2:0]         nextSel;
    logic [1:0]         condSel;
    logic               condInv;
    logic [STATE_W-1:0] crAddr;
    logic [STATE_W-1:0] encodedState;
    logic               moc;
    logic               branchCond;
    logic               aluZero;
    logic [STATE_W-1:0] currentState;
    logic               holding;
    logic               illegalState;
    logic               wdFault;

    // Control unit side: drives the microstore fields, observes the state
    modport master (
        output nextSel, condSel, condInv, crAddr, encodedState,
        output moc, branchCond, aluZero,
        input  currentState, holding, illegalState, wdFault
    );

    // Sequencer side
    modport slave (
        input  nextSel, condSel, condInv, crAddr, encodedState,
        input  moc, branchCond, aluZero,
        output currentState, holding, illegalState, wdFault
    );
endinterface
`default_nettype wire

// File: rtl/microstore_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : microstore_sequencer
//  Purpose  : Next-state address generator for the microprogrammed control
//             unit. Holds the control state register and the incrementer
//             register, selects the branch condition and replaces any state
//             above MAX_STATE with state 0.
//  Option   : SEQ_WATCHDOG_EN - adds a hold-cycle watchdog that forces state 0
//             after WD_LIMIT consecutive holding cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module microstore_sequencer #(
    parameter int STATE_W     = 7,
    parameter int FETCH_STATE = 1,
    parameter int MAX_STATE   = 40,
    parameter int WD_LIMIT    = 255
) (
    input  wire logic              clk,
    input  wire logic              reset,
    microstore_sequencer_if.slave  bus
);

    localparam logic [STATE_W-1:0] c_FETCH = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] c_ZERO  = '0;
    localparam logic [STATE_W-1:0] c_ONE   = STATE_W'(1);
    // One extra bit so MAX_STATE = 2^STATE_W-1 still compares correctly
    localparam logic [STATE_W:0]   c_MAX   = (STATE_W+1)'(MAX_STATE);

    // The hold counter is 8 bits wide and MAX_STATE must be a real state
    if (WD_LIMIT < 1 || WD_LIMIT > 255) begin : g_bad_wd_limit
        $error("microstore_sequencer: WD_LIMIT must be in 1..255");
    end
    if (MAX_STATE < 0 || MAX_STATE >= (1 << STATE_W)) begin : g_bad_max_state
        $error("microstore_sequencer: MAX_STATE must fit in STATE_W bits");
    end

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] r_inc;
    logic               r_illegal;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_next_eff;
    logic               w_cond;
    logic               w_illegal;
    logic               w_holding;
    logic               w_wd_fire;

    // Condition mux with optional inversion
    always_comb begin
        w_cond = 1'b1;
        case (bus.condSel)
            2'b00:   w_cond = bus.moc;
            2'b01:   w_cond = bus.branchCond;
            2'b10:   w_cond = bus.aluZero;
            default: w_cond = 1'b1;
        endcase
        w_cond = w_cond ^ bus.condInv;
    end

    // Next-address selection from the nextSel field
    always_comb begin
        w_next = r_state;
        case (bus.nextSel)
            3'b000:  w_next = bus.encodedState;
            3'b001:  w_next = c_FETCH;
            3'b010:  w_next = bus.crAddr;
            3'b011:  w_next = r_inc;
            3'b100:  w_next = w_cond ? bus.crAddr : bus.encodedState;
            3'b101:  w_next = w_cond ? bus.crAddr : r_inc;
            3'b110:  w_next = w_cond ? r_inc      : bus.encodedState;
            default: w_next = w_cond ? r_inc      : r_state;
        endcase
    end

    // Illegal-state guard; holding reflects the state actually loaded
    assign w_illegal  = ({1'b0, w_next} > c_MAX);
    assign w_next_eff = w_illegal ? c_ZERO : w_next;
    assign w_holding  = (w_next_eff == r_state);

`ifdef SEQ_WATCHDOG_EN
    localparam logic [7:0] c_WD_LIMIT = 8'(WD_LIMIT);

    logic [7:0] r_hold_cnt;
    logic       r_wdfault;

    assign w_wd_fire = w_holding && ((r_hold_cnt + 8'd1) == c_WD_LIMIT);

    // Count consecutive holding cycles; clear on release or on expiry
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= 8'd0;
            r_wdfault  <= 1'b0;
        end else if (w_wd_fire) begin
            r_hold_cnt <= 8'd0;
            r_wdfault  <= 1'b1;
        end else begin
            r_hold_cnt <= w_holding ? (r_hold_cnt + 8'd1) : 8'd0;
            r_wdfault  <= 1'b0;
        end
    end

    assign bus.wdFault = r_wdfault;
`else
    assign w_wd_fire   = 1'b0;
    assign bus.wdFault = 1'b0;
`endif

    // State and incrementer registers: reset > watchdog > illegal > normal
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ZERO;
            r_inc     <= c_ONE;
            r_illegal <= 1'b0;
        end else if (w_wd_fire) begin
            r_state   <= c_ZERO;
            r_inc     <= c_ONE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next_eff;
            r_inc     <= w_next_eff + c_ONE;
            r_illegal <= w_illegal;
        end
    end

    assign bus.currentState = r_state;
    assign bus.holding      = w_holding;
    assign bus.illegalState = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_microstore_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microstore_sequencer
//  Purpose  : Self-checking bench for microstore_sequencer: directed steps
//             followed by random sequencing fields, all compared against a
//             behavioural next-state model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_microstore_sequencer;

    localparam int SW  = 7;
    localparam int MAX = 40;
    localparam int WDL = 255;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    microstore_sequencer_if #(.STATE_W(SW)) bus ();

    microstore_sequencer #(
        .STATE_W     (SW),
        .FETCH_STATE (1),
        .MAX_STATE   (MAX),
        .WD_LIMIT    (WDL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_cur  = 0;
    int m_ill  = 0;
    int m_wd   = 0;
    int m_hcnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next state straight from the selection table; incReg is current+1
    function automatic int model_next();
        int c;
        int inc;
        case (bus.condSel)
            2'd0:    c = int'(bus.moc);
            2'd1:    c = int'(bus.branchCond);
            2'd2:    c = int'(bus.aluZero);
            default: c = 1;
        endcase
        if (bus.condInv) c = 1 - c;
        inc = (m_cur + 1) % (1 << SW);
        case (bus.nextSel)
            3'd0:    return int'(bus.encodedState);
            3'd1:    return 1;
            3'd2:    return int'(bus.crAddr);
            3'd3:    return inc;
            3'd4:    return (c != 0) ? int'(bus.crAddr) : int'(bus.encodedState);
            3'd5:    return (c != 0) ? int'(bus.crAddr) : inc;
            3'd6:    return (c != 0) ? inc : int'(bus.encodedState);
            default: return (c != 0) ? inc : m_cur;
        endcase
    endfunction

    // One clock: check holding before the edge, advance model, check after
    task automatic tick();
        int nx;
        int eff;
        int hold;
        int fired;
        #2;
        nx    = model_next();
        eff   = (nx > MAX) ? 0 : nx;
        hold  = (eff == m_cur) ? 1 : 0;
        fired = 0;
        if (!reset) check("holding", 32'(bus.holding), 32'(hold));
        if (reset) begin
            m_cur = 0; m_ill = 0; m_wd = 0; m_hcnt = 0;
        end else begin
            m_wd = 0;
`ifdef SEQ_WATCHDOG_EN
            if (hold != 0) begin
                if (m_hcnt + 1 == WDL) begin fired = 1; m_hcnt = 0; end
                else m_hcnt++;
            end else begin
                m_hcnt = 0;
            end
`endif
            if (fired != 0)   begin m_cur = 0;  m_ill = 0; m_wd = 1; end
            else if (nx > MAX) begin m_cur = 0;  m_ill = 1; end
            else               begin m_cur = nx; m_ill = 0; end
        end
        @(posedge clk);
        #1;
        check("currentState", 32'(bus.currentState), 32'(m_cur));
        check("illegalState", 32'(bus.illegalState), 32'(m_ill));
        check("wdFault",      32'(bus.wdFault),      32'(m_wd));
    endtask

    task automatic set_fields(input int ns, input int cs, input int inv,
                              input int cr, input int enc);
        bus.nextSel      = 3'(ns);
        bus.condSel      = 2'(cs);
        bus.condInv      = 1'(inv);
        bus.crAddr       = SW'(cr);
        bus.encodedState = SW'(enc);
    endtask

    initial begin
        reset          = 1'b1;
        bus.moc        = 1'b0;
        bus.branchCond = 1'b0;
        bus.aluZero    = 1'b0;
        set_fields(3, 0, 0, 0, 0);

        // Reset held two cycles while asking for the incrementer
        tick();
        tick();
        check("reset_state", 32'(bus.currentState), 32'd0);
        reset = 1'b0;
        set_fields(1, 0, 0, 0, 0);
        tick();
        check("fetch", 32'(bus.currentState), 32'd1);

        // Decode then increment
        set_fields(0, 0, 0, 0, 6);
        tick();
        check("decode", 32'(bus.currentState), 32'd6);
        set_fields(3, 0, 0, 0, 0);
        tick();
        check("increment", 32'(bus.currentState), 32'd7);

        // MOC polling hold at state 4
        set_fields(2, 0, 0, 4, 0);
        tick();
        set_fields(7, 0, 0, 0, 0);
        bus.moc = 1'b0;
        repeat (5) tick();
        check("hold_state", 32'(bus.currentState), 32'd4);
        bus.moc = 1'b1;
        tick();
        check("hold_release", 32'(bus.currentState), 32'd5);

        // Inverted branch condition: taken to crAddr, then falls to incReg
        bus.branchCond = 1'b0;
        set_fields(5, 1, 1, 20, 0);
        tick();
        check("branch_taken", 32'(bus.currentState), 32'd20);
        set_fields(2, 0, 0, 19, 0);
        tick();
        bus.branchCond = 1'b1;
        set_fields(5, 1, 1, 20, 0);
        tick();
        check("branch_inc", 32'(bus.currentState), 32'd20);

        // Illegal target, its one-cycle pulse, then reset beating it
        set_fields(2, 0, 0, 45, 0);
        tick();
        check("illegal_pulse", 32'(bus.illegalState), 32'd1);
        set_fields(2, 0, 0, 3, 0);
        tick();
        check("illegal_clear", 32'(bus.illegalState), 32'd0);
        set_fields(2, 0, 0, 45, 0);
        reset = 1'b1;
        tick();
        check("reset_over_illegal", 32'(bus.illegalState), 32'd0);
        reset = 1'b0;

        // Conditional branch to an illegal target
        bus.aluZero = 1'b1;
        set_fields(4, 2, 0, 60, 9);
        tick();

        // Long hold at state 4
        set_fields(2, 0, 0, 4, 0);
        tick();
        bus.moc = 1'b0;
        set_fields(7, 0, 0, 0, 0);
        repeat (300) tick();

        // Reset in the middle of a hold
        set_fields(2, 0, 0, 9, 0);
        tick();
        set_fields(7, 0, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Random sequencing fields and condition inputs
        for (int i = 0; i < 400; i++) begin
            reset          = ($urandom_range(0, 99) < 3);
            bus.moc        = 1'($urandom_range(0, 1));
            bus.branchCond = 1'($urandom_range(0, 1));
            bus.aluZero    = 1'($urandom_range(0, 1));
            set_fields(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 50)),
                       int'($urandom_range(0, 50)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/microstore_sequencer.md
Name: microstore_sequencer

Overview:
- Next-state address generator for the microprogrammed control unit.
- Holds the 7-bit control state register that drives the microstore's state input.
- Each cycle it consumes the microstore's sequencing fields (next-address select, condition select, invert, target address) and chooses the next state from the encoder, the target address, the incrementer or the current state.
- Contains the state register, the incrementer register, the condition mux and the illegal-state guard.

Parameters:
- STATE_W, 7, state width in bits. Must match the microstore state input.
- FETCH_STATE, 1, state loaded when the next-address select is 001.
- MAX_STATE, 40, highest legal state; any larger computed next state is illegal.
- WD_LIMIT, 255, watchdog hold-cycle limit (used only with SEQ_WATCHDOG_EN).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- nextSel  input  3  N2..N0 next-address select field from the microstore.
- condSel  input  2  selects the condition source: 00 moc, 01 branchCond, 10 aluZero, 11 constant 1.
- condInv  input  1  inverts the selected condition.
- crAddr  input  STATE_W  microstore target state (CR field).
- encodedState  input  STATE_W  instruction-encoder state for the current IR.
- moc  input  1  memory operation complete.
- branchCond  input  1  branch-condition tester output.
- aluZero  input  1  ALU zero flag.
- currentState  output  STATE_W  registered state to the microstore.
- holding  output  1  high in any cycle where the selected next state equals currentState.
- illegalState  output  1  registered one-cycle pulse when an illegal next state was replaced by 0.
- wdFault  output  1  registered one-cycle pulse on watchdog expiry (0 when the feature is compiled out).

Behaviour:
Condition:
- cond = mux(condSel) XOR condInv. Purely combinational, sampled at the clock edge.

incReg:
- incReg <= (nextState + 1) mod 2^STATE_W every cycle.
- 127 wraps to 0.
- Invariant: incReg == currentState + 1.

nextState by nextSel:
- 000: encodedState
- 001: FETCH_STATE
- 010: crAddr
- 011: incReg
- 100: cond ? crAddr : encodedState
- 101: cond ? crAddr : incReg
- 110: cond ? incReg : encodedState
- 111: cond ? incReg : currentState (wait/hold, used for MOC polling)

Register update, in priority order:
- reset=1: currentState <= 0, incReg <= 1, illegalState <= 0, wdFault <= 0, watchdog counter <= 0.
- Else if nextState > MAX_STATE: currentState <= 0, incReg <= 1, illegalState <= 1 for exactly one cycle.
- Else: currentState <= nextState, illegalState <= 0.

Outputs and timing:
- Reset values: currentState = 0, illegalState = 0, wdFault = 0. holding is combinational.
- Latency: one clock from sequencing fields to the new currentState. No combinational path from inputs to currentState.
- holding = (nextState == currentState) after the illegal check. It also covers 010 with crAddr == currentState.

Boundary conditions:
- Reset asserted mid-hold (111): aborts the hold, state goes to 0 on that edge, watchdog counter clears.
- Reset has priority over the illegal check and the watchdog in the same cycle.
- Inputs with X/undefined values are out of scope; the bench drives only defined values.
- Simultaneous cond=1 and illegal target: the illegal rule applies, giving state 0 and an illegalState pulse.
- State 127 under 011 (only reachable when MAX_STATE = 127): incReg = 0, so next state is 0 with no illegal flag.

Optional Feature:
SEQ_WATCHDOG_EN
- Defined:
  - An 8-bit hold counter increments each cycle holding=1 and clears when holding=0.
  - When the counter reaches WD_LIMIT while holding: currentState <= 0, incReg <= 1, wdFault pulses for one cycle, counter clears.
  - The watchdog loses to reset and beats the illegal check in the same cycle.
- Undefined:
  - No counter logic is generated.
  - wdFault is tied to 0.
  - A hold lasts indefinitely.

Test Plan:
1. Assert reset 2 cycles with nextSel=011 -> currentState=0 and incReg=1 throughout. First edge after release with nextSel=001 -> currentState=1.
2. currentState=1, nextSel=000, encodedState=6 -> currentState=6. Next cycle nextSel=011 -> currentState=7.
3. currentState=4, nextSel=111, condSel=00, condInv=0, moc=0 for 5 cycles -> currentState stays 4, holding=1. moc=1 -> currentState=5 next edge, holding=0.
4. nextSel=101, condSel=01, condInv=1, branchCond=0, crAddr=20 -> currentState=20. Repeat with branchCond=1 from currentState=19 -> currentState=20 via incReg.
5. nextSel=010, crAddr=45 (MAX_STATE=40) -> currentState=0 and illegalState=1 for exactly one cycle. Reset asserted in the same cycle -> currentState=0, illegalState=0.
6. With SEQ_WATCHDOG_EN and WD_LIMIT=8: hold at state 4 with moc=0 -> after 8 held cycles currentState=0 and wdFault pulses once. Without the macro -> still at 4 after 300 cycles, wdFault=0.
